fifo_sync_core: RTL and testbench

//  Single-clock first-in first-out buffer with full/empty flags and a first-word-fall-through read port.

---
 rtl/fifo_sync_core.sv | 39 +++
 tb/tb_fifo_sync_core.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_core.sv
// fifo_sync_core: single-clock first-word-fall-through FIFO with full/empty flags and usage count
module fifo_sync_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     w_en_i,
  input  logic [DATA_WIDTH-1:0]    w_data_i,
  input  logic                     r_en_i,
  output logic [DATA_WIDTH-1:0]    r_data_o,
  output logic                     w_full_o,
  output logic                     r_empty_o,
  output logic [$clog2(DEPTH):0]   usage_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic wr_ok, rd_ok;
  assign wr_ok = w_en_i && !w_full_o;
  assign rd_ok = r_en_i && !r_empty_o;
  assign r_empty_o = wptr == rptr;
  // wrap bits differ but addresses match: the writer is a full lap ahead
  assign w_full_o = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign usage_o = wptr - rptr;
  assign r_data_o = mem[rptr[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= w_data_i;
  end
endmodule

// File: tb/tb_fifo_sync_core.sv
// tb_fifo_sync_core: vector table plus scoreboard-driven sequences for the FWFT FIFO core
module tb_fifo_sync_core;
  localparam int DW = 8;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic w_en_i = 1'b0;
  logic [DW-1:0] w_data_i = '0;
  logic r_en_i = 1'b0;
  logic [DW-1:0] r_data_o;
  logic w_full_o, r_empty_o;
  logic [$clog2(DEPTH):0] usage_o;
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] q[$];
  typedef struct {
    logic w;
    logic [DW-1:0] d;
    logic r;
    int usage;
    logic empty;
    logic full;
    logic [DW-1:0] data;
  } vec_t;
  vec_t vt[8];

  fifo_sync_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .w_en_i(w_en_i),
    .w_data_i(w_data_i),
    .r_en_i(r_en_i),
    .r_data_o(r_data_o),
    .w_full_o(w_full_o),
    .r_empty_o(r_empty_o),
    .usage_o(usage_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("usage", int'(usage_o), q.size());
    chk("empty", int'(r_empty_o), int'(q.size() == 0));
    chk("full", int'(w_full_o), int'(q.size() == DEPTH));
    if (q.size() > 0) chk("head", int'(r_data_o), int'(q[0]));
  endtask

  // called just after a falling edge; returns just after the next falling edge
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    bit wacc, racc;
    wacc = w && (q.size() < DEPTH);
    racc = r && (q.size() > 0);
    w_en_i = w;
    w_data_i = d;
    r_en_i = r;
    if (racc) chk("pop_data", int'(r_data_o), int'(q[0]));
    if (wacc) q.push_back(d);
    @(posedge clk);
    #1;
    w_en_i = 1'b0;
    r_en_i = 1'b0;
    if (racc) void'(q.pop_front());
    @(negedge clk);
    #1;
    check_state();
  endtask

  task automatic drain();
    while (q.size() > 0) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    int pushes;
    int sz;
    logic w, r;
    vt[0] = '{1'b1, 8'h10, 1'b0, 1, 1'b0, 1'b0, 8'h10};
    vt[1] = '{1'b1, 8'h20, 1'b0, 2, 1'b0, 1'b0, 8'h10};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h20};
    vt[3] = '{1'b1, 8'h30, 1'b1, 1, 1'b0, 1'b0, 8'h30};
    vt[4] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
    vt[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
    vt[6] = '{1'b1, 8'h40, 1'b1, 1, 1'b0, 1'b0, 8'h40};
    vt[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};

    r_en_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_empty", int'(r_empty_o), 1);
    chk("rst_full", int'(w_full_o), 0);
    chk("rst_usage", int'(usage_o), 0);
    rst_ni = 1'b1;
    r_en_i = 1'b0;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    foreach (vt[i]) begin
      cycle(vt[i].w, vt[i].d, vt[i].r);
      chk("vec_usage", int'(usage_o), vt[i].usage);
      chk("vec_empty", int'(r_empty_o), int'(vt[i].empty));
      chk("vec_full", int'(w_full_o), int'(vt[i].full));
      if (!vt[i].empty) chk("vec_data", int'(r_data_o), int'(vt[i].data));
    end

    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0);
    chk("fill_full", int'(w_full_o), 1);
    chk("fill_usage", int'(usage_o), DEPTH);
    cycle(1'b1, 8'hEE, 1'b0);
    chk("over_usage", int'(usage_o), DEPTH);
    drain();
    chk("drain_empty", int'(r_empty_o), 1);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 60; i++) cycle(i % 2 == 0, DW'($urandom), i % 2 == 1);

    drain();
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, DW'($urandom), 1'b1);
      chk("simul_usage", int'(usage_o), 5);
    end

    while (q.size() < DEPTH) cycle(1'b1, DW'($urandom), 1'b0);
    cycle(1'b1, 8'h77, 1'b1);
    chk("full_rw_usage", int'(usage_o), DEPTH - 1);
    for (int i = 0; i < 9; i++) cycle(1'b1, DW'($urandom), 1'b1);

    drain();
    pushes = 0;
    while (pushes < 100) begin
      sz = q.size();
      w = sz <= 1 ? 1'b1 : sz >= 31 ? 1'b0 : 1'(($urandom_range(1)));
      r = sz <= 1 ? 1'b0 : sz >= 31 ? 1'b1 : 1'(($urandom_range(1)));
      cycle(w, DW'($urandom), r);
      if (w) pushes++;
      chk("wrap_range", int'(usage_o >= 1 && usage_o <= 31), 1);
    end

    drain();
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_empty", int'(r_empty_o), 1);
    chk("midrst_full", int'(w_full_o), 0);
    chk("midrst_usage", int'(usage_o), 0);
    #1 rst_ni = 1'b1;
    q.delete();
    cycle(1'b1, 8'h11, 1'b0);
    chk("post_rst_data", int'(r_data_o), 8'h11);
    cycle(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
